mcpu_ram_controller: RTL and testbench

- Unified 256x8 main memory for the MCPU.
- One synchronous write port; two independent combinational read ports:
  - data port, for load/store;
  - instruction port, for fetch.
- Sits between the CPU core and the memory array, so fetch and data access proceed in the same cycle without arbitration.

---
 rtl/mcpu_ram_pkg.sv | 11 +
 rtl/mcpu_ram_array.sv | 33 +++
 rtl/mcpu_ram_controller.sv | 49 ++++
 tb/tb_mcpu_ram_controller.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mcpu_ram_pkg.sv
// Shared sizing constants and word/address types for the MCPU unified main memory.
package mcpu_ram_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int ADDR_WIDTH = 8;
  localparam int RAM_SIZE   = 1 << ADDR_WIDTH;

  typedef logic [WORD_SIZE-1:0]  word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/mcpu_ram_array.sv
// RAM_SIZE x WORD_SIZE storage: one synchronous write/clear port, two combinational read ports.
// Reads see the stored contents, so a same-cycle write becomes visible only after the edge.
module mcpu_ram_array
  import mcpu_ram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en_i,
  input  addr_t wr_addr_i,
  input  word_t wr_dat_i,
  input  addr_t rd0_addr_i,
  output word_t rd0_dat_o,
  input  addr_t rd1_addr_i,
  output word_t rd1_dat_o
);

  word_t mem_q [RAM_SIZE];

  // Reset wipes every word and takes priority over a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAM_SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd0_dat_o = mem_q[rd0_addr_i];
  assign rd1_dat_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/mcpu_ram_controller.sv
// MCPU main memory: data port (re-gated load/store) and always-on fetch port, zero-cycle reads.
// Optional write-through forwarding to both read ports under `MCPU_RAM_BYPASS_EN.
module mcpu_ram_controller
  import mcpu_ram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  word_t datawr,
  input  logic  re,
  input  addr_t addr,
  output word_t datard,
  input  addr_t instraddr,
  output word_t instrrd
);

  word_t data_word;
  word_t instr_word;

  mcpu_ram_array u_array (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (we),
    .wr_addr_i  (addr),
    .wr_dat_i   (datawr),
    .rd0_addr_i (addr),
    .rd0_dat_o  (data_word),
    .rd1_addr_i (instraddr),
    .rd1_dat_o  (instr_word)
  );

  always_comb begin
    datard  = '0;
    instrrd = instr_word;
    if (re) begin
      datard = data_word;
    end
`ifdef MCPU_RAM_BYPASS_EN
    // Data read and write share one address, so a concurrent write always hits.
    if (we && re) begin
      datard = datawr;
    end
    if (we && (instraddr == addr)) begin
      instrrd = datawr;
    end
`endif
  end

endmodule

// File: tb/tb_mcpu_ram_controller.sv
// Directed bench for mcpu_ram_controller: reset clear, full fill/readback, port independence,
// re gating, read-during-write and reset priority.
module tb_mcpu_ram_controller;

  logic       clk;
  logic       rst;
  logic       we;
  logic [7:0] datawr;
  logic       re;
  logic [7:0] addr;
  logic [7:0] datard;
  logic [7:0] instraddr;
  logic [7:0] instrrd;

  int n_cmp;
  int n_err;

  logic [7:0] pat [8];
  logic [7:0] rdw_pre;

  mcpu_ram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .datawr    (datawr),
    .re        (re),
    .addr      (addr),
    .datard    (datard),
    .instraddr (instraddr),
    .instrrd   (instrrd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    pat[0] = 8'h04; pat[1] = 8'h06; pat[2] = 8'h05; pat[3] = 8'h04;
    pat[4] = 8'h04; pat[5] = 8'h07; pat[6] = 8'h03; pat[7] = 8'h09;

    rst = 1'b1; we = 1'b0; re = 1'b0; datawr = '0; addr = '0; instraddr = '0;
    tick();
    rst = 1'b0;
    re  = 1'b1;
    #1;

    for (int k = 0; k < 256; k++) begin
      addr = 8'(k); instraddr = 8'(k);
      #1;
      chk($sformatf("rst_data[%0d]", k), datard, 8'h00);
      chk($sformatf("rst_instr[%0d]", k), instrrd, 8'h00);
    end

    re = 1'b0;
    we = 1'b1;
    for (int k = 0; k < 256; k++) begin
      addr = 8'(k); datawr = pat[k % 8];
      tick();
    end
    we = 1'b0;
    re = 1'b1;

    for (int k = 0; k < 256; k++) begin
      addr = 8'(k); instraddr = 8'(k);
      #1;
      chk($sformatf("fill_data[%0d]", k), datard, pat[k % 8]);
      chk($sformatf("fill_instr[%0d]", k), instrrd, pat[k % 8]);
    end

    addr = 8'd7;   #1; chk("fill_a7",   datard, 8'h09);
    addr = 8'd255; #1; chk("fill_a255", datard, 8'h09);
    addr = 8'd250; #1; chk("fill_a250", datard, 8'h05);

    addr = 8'd3; instraddr = 8'd7;
    #1;
    chk("indep_data",  datard,  8'h04);
    chk("indep_instr", instrrd, 8'h09);

    re = 1'b0; addr = 8'd5; instraddr = 8'd5;
    #1;
    chk("regate_data",  datard,  8'h00);
    chk("regate_instr", instrrd, 8'h07);

`ifdef MCPU_RAM_BYPASS_EN
    rdw_pre = 8'hAA;
`else
    rdw_pre = 8'h04;
`endif
    re = 1'b1; we = 1'b1; datawr = 8'hAA; addr = 8'h10; instraddr = 8'h10;
    #1;
    chk("rdw_pre_data",  datard,  rdw_pre);
    chk("rdw_pre_instr", instrrd, rdw_pre);
    tick();
    we = 1'b0;
    #1;
    chk("rdw_post_data",  datard,  8'hAA);
    chk("rdw_post_instr", instrrd, 8'hAA);
    addr = 8'h11; instraddr = 8'h0F;
    #1;
    chk("rdw_neigh_data",  datard,  8'h06);
    chk("rdw_neigh_instr", instrrd, 8'h09);

    rst = 1'b1; we = 1'b1; addr = 8'h20; datawr = 8'h55; instraddr = 8'h20;
    tick();
    rst = 1'b0; we = 1'b0; re = 1'b1;
    #1;
    chk("rstpri_data",  datard,  8'h00);
    chk("rstpri_instr", instrrd, 8'h00);
    for (int k = 0; k < 256; k++) begin
      addr = 8'(k); instraddr = 8'(255 - k);
      #1;
      chk($sformatf("rstpri_data[%0d]", k), datard, 8'h00);
      chk($sformatf("rstpri_instr[%0d]", 255 - k), instrrd, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
